// File: rtl/asrv32_memory.sv
// rtl/asrv32_memory.sv - unified fetch/load-store RAM with one-cycle reads and an MMIO window
// Optional MMIO block (mtime, console, ID) is built only when ASRV32_MMIO_EN is defined.
module asrv32_memory #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter              INIT_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst_addr,
  output logic [31:0] o_inst,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_store_data,
  input  logic [3:0]  i_wr_mask,
  input  logic        i_wr_en,
  output logic [31:0] o_data_from_memory,
  output logic        o_addr_err,
  output logic [7:0]  o_console_data,
  output logic        o_console_valid
);

  localparam int AW = $clog2(MEM_DEPTH);
`ifdef ASRV32_MMIO_EN
  localparam logic MMIO_ON = 1'b1;
`else
  localparam logic MMIO_ON = 1'b0;
`endif

  logic [31:0]   mem_q [MEM_DEPTH];
  logic [31:0]   inst_q, data_q;
  logic          err_q;
  logic          inst_in_ram, data_in_ram, data_in_mmio, data_wr;
  logic [AW-1:0] inst_idx, data_idx;
  logic [31:0]   mmio_rdata;
  logic          unused_addr_lsbs;

  assign inst_in_ram  = (i_inst_addr[31:AW+2] == '0);
  assign data_in_ram  = (i_data_addr[31:AW+2] == '0);
  assign data_in_mmio = MMIO_ON && (i_data_addr[31:4] == MMIO_BASE[31:4]);
  assign inst_idx     = i_inst_addr[AW+1:2];
  assign data_idx     = i_data_addr[AW+1:2];
  assign data_wr      = i_wr_en && data_in_ram && !i_rst;
  assign unused_addr_lsbs = ^{i_inst_addr[1:0], i_data_addr[1:0]};

  // RAM is never reset; reads below see the pre-write word (read-first).
  always_ff @(posedge i_clk) begin
    if (data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_mask[b]) mem_q[data_idx][8*b +: 8] <= i_store_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inst_q <= 32'h0000_0013;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      inst_q <= inst_in_ram ? mem_q[inst_idx] : '0;
      data_q <= data_in_ram ? mem_q[data_idx] : mmio_rdata;
      err_q  <= err_q | !inst_in_ram | (!data_in_ram & !data_in_mmio);
    end
  end

`ifdef ASRV32_MMIO_EN
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtime_wdata;
  logic [7:0]  mtime_mask;
  logic        mmio_wr, console_wr;
  logic [7:0]  console_data_q;
  logic        console_valid_q;

  assign mmio_wr     = i_wr_en && data_in_mmio;
  assign console_wr  = mmio_wr && (i_data_addr[3:2] == 2'd2) && i_wr_mask[0];
  assign mtime_wdata = {i_store_data, i_store_data};
  assign mtime_mask  = (mmio_wr && !i_data_addr[3])
                       ? (i_data_addr[2] ? {i_wr_mask, 4'b0000} : {4'b0000, i_wr_mask})
                       : 8'h00;

  // Any mtime write freezes all 64 bits for that cycle; written bytes take the new value.
  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (|mtime_mask) begin
      mtime_d = mtime_q;
      for (int b = 0; b < 8; b++) begin
        if (mtime_mask[b]) mtime_d[8*b +: 8] = mtime_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (data_in_mmio) begin
      case (i_data_addr[3:2])
        2'd0:    mmio_rdata = mtime_q[31:0];
        2'd1:    mmio_rdata = mtime_q[63:32];
        2'd3:    mmio_rdata = 32'h4153_5256;
        default: mmio_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_q         <= '0;
      console_data_q  <= '0;
      console_valid_q <= 1'b0;
    end else begin
      mtime_q         <= mtime_d;
      console_valid_q <= console_wr;
      if (console_wr) console_data_q <= i_store_data[7:0];
    end
  end

  assign o_console_data  = console_data_q;
  assign o_console_valid = console_valid_q;
`else
  assign mmio_rdata      = '0;
  assign o_console_data  = '0;
  assign o_console_valid = 1'b0;
`endif

  assign o_inst             = inst_q;
  assign o_data_from_memory = data_q;
  assign o_addr_err         = err_q;

endmodule

// File: tb/tb_asrv32_memory.sv
// tb/tb_asrv32_memory.sv - directed self-checking bench for asrv32_memory
// Exercises the MMIO block when ASRV32_MMIO_EN is defined, the fault decode otherwise.
module tb_asrv32_memory;

  localparam logic [31:0] MMIO = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr, data_addr, store_data;
  logic [3:0]  wr_mask;
  logic        wr_en;
  logic [31:0] inst, data_rd;
  logic        addr_err;
  logic [7:0]  con_data;
  logic        con_valid;

  int tests_run = 0;
  int tests_failed = 0;

  asrv32_memory #(.MEM_DEPTH(1024), .MMIO_BASE(MMIO), .INIT_FILE("")) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_inst_addr(inst_addr),
    .o_inst(inst),
    .i_data_addr(data_addr),
    .i_store_data(store_data),
    .i_wr_mask(wr_mask),
    .i_wr_en(wr_en),
    .o_data_from_memory(data_rd),
    .o_addr_err(addr_err),
    .o_console_data(con_data),
    .o_console_valid(con_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, then sample just after the following falling edge.
  task automatic cyc(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                     input logic [3:0] m, input logic we);
    inst_addr  = ia;
    data_addr  = da;
    store_data = wd;
    wr_mask    = m;
    wr_en      = we;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_addr = '0; data_addr = '0; store_data = '0; wr_mask = '0; wr_en = 1'b0;
    do_reset();
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_data", data_rd, 32'h0);
    check("rst_err", {31'b0, addr_err}, 32'h0);
    check("rst_con_valid", {31'b0, con_valid}, 32'h0);
    check("rst_con_data", {24'b0, con_data}, 32'h0);

`ifdef ASRV32_MMIO_EN
    for (int i = 0; i < 10; i++) cyc(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(32'h0, MMIO, 32'h0, 4'h0, 1'b0);
    check("mtime_lo_10", data_rd, 32'h0000_000A);
    cyc(32'h0, MMIO + 32'h4, 32'h0, 4'h0, 1'b0);
    check("mtime_hi_0", data_rd, 32'h0);
    cyc(32'h0, MMIO, 32'hFFFF_FFFF, 4'hF, 1'b1);
    cyc(32'h0, MMIO + 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    cyc(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(32'h0, MMIO, 32'h0, 4'h0, 1'b0);
    check("mtime_wrap_lo", data_rd, 32'h0);
    cyc(32'h0, MMIO + 32'h4, 32'h0, 4'h0, 1'b0);
    check("mtime_wrap_hi", data_rd, 32'h0);
    cyc(32'h0, MMIO, 32'h1234_56AB, 4'h1, 1'b1);
    cyc(32'h0, MMIO, 32'h0, 4'h0, 1'b0);
    check("mtime_byte_wr", data_rd, 32'h0000_00AB);
`endif

    cyc(32'h0, 32'h0, 32'h0050_0093, 4'hF, 1'b1);
    cyc(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("fetch_word0", inst, 32'h0050_0093);
    cyc(32'h0, 32'h40, 32'hAABB_CCDD, 4'hF, 1'b1);
    cyc(32'h40, 32'h40, 32'h1122_3344, 4'h4, 1'b1);
    check("rdw_data_old", data_rd, 32'hAABB_CCDD);
    check("rdw_inst_old", inst, 32'hAABB_CCDD);
    cyc(32'h40, 32'h40, 32'h0, 4'h0, 1'b0);
    check("masked_store", data_rd, 32'hAA22_CCDD);
    check("masked_fetch", inst, 32'hAA22_CCDD);
    cyc(32'h0, 32'h40, 32'hDEAD_BEEF, 4'h0, 1'b1);
    cyc(32'h0, 32'h42, 32'h0, 4'h0, 1'b0);
    check("empty_mask_lsb_ignored", data_rd, 32'hAA22_CCDD);
    check("empty_mask_no_err", {31'b0, addr_err}, 32'h0);
    cyc(32'h0, 32'hFFC, 32'h1234_5678, 4'hF, 1'b1);
    cyc(32'hFFC, 32'hFFC, 32'h0, 4'h0, 1'b0);
    check("top_word", data_rd, 32'h1234_5678);
    check("top_word_no_err", {31'b0, addr_err}, 32'h0);

    cyc(32'h0, 32'h0001_0000, 32'h0, 4'h0, 1'b0);
    check("fault_rd_zero", data_rd, 32'h0);
    check("fault_err_set", {31'b0, addr_err}, 32'h1);
    cyc(32'h0, 32'h0001_0000, 32'hCAFE_F00D, 4'hF, 1'b1);
    cyc(32'h0, 32'h0001_0000, 32'h0, 4'h0, 1'b0);
    check("fault_wr_ignored", data_rd, 32'h0);
    cyc(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("fault_no_alias", data_rd, 32'h0050_0093);
    check("fault_err_sticky", {31'b0, addr_err}, 32'h1);

    rst = 1'b1;
    cyc(32'h0, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rst = 1'b0;
    check("rst_clears_err", {31'b0, addr_err}, 32'h0);
    cyc(32'h0, 32'h40, 32'h0, 4'h0, 1'b0);
    check("rst_store_dropped", data_rd, 32'hAA22_CCDD);
    cyc(32'h1000, 32'h0, 32'h0, 4'h0, 1'b0);
    check("fetch_fault_zero", inst, 32'h0);
    check("fetch_fault_err", {31'b0, addr_err}, 32'h1);
    do_reset();

`ifdef ASRV32_MMIO_EN
    cyc(32'h0, MMIO + 32'h8, 32'h0000_0041, 4'h1, 1'b1);
    check("con_valid", {31'b0, con_valid}, 32'h1);
    check("con_data", {24'b0, con_data}, 32'h41);
    cyc(32'h0, MMIO + 32'h8, 32'h0, 4'h0, 1'b0);
    check("con_one_cycle", {31'b0, con_valid}, 32'h0);
    check("con_rd_zero", data_rd, 32'h0);
    cyc(32'h0, MMIO + 32'h8, 32'h0000_0042, 4'h1, 1'b1);
    cyc(32'h0, MMIO + 32'h8, 32'h0000_0043, 4'h1, 1'b1);
    check("con_b2b_valid", {31'b0, con_valid}, 32'h1);
    check("con_b2b_data", {24'b0, con_data}, 32'h43);
    cyc(32'h0, MMIO + 32'h8, 32'h0000_0044, 4'h2, 1'b1);
    check("con_mask_lane1", {31'b0, con_valid}, 32'h0);
    cyc(32'h0, MMIO + 32'hC, 32'h1111_1111, 4'hF, 1'b1);
    check("id_read", data_rd, 32'h4153_5256);
    check("mmio_no_err", {31'b0, addr_err}, 32'h0);
`else
    cyc(32'h0, MMIO + 32'hC, 32'h0, 4'h0, 1'b0);
    check("nommio_id_zero", data_rd, 32'h0);
    check("nommio_err", {31'b0, addr_err}, 32'h1);
    do_reset();
    cyc(32'h0, MMIO + 32'h8, 32'h0000_0041, 4'h1, 1'b1);
    check("nommio_con_valid", {31'b0, con_valid}, 32'h0);
    check("nommio_con_data", {24'b0, con_data}, 32'h0);
    cyc(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("nommio_con_valid2", {31'b0, con_valid}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
